// File: rtl/axi4_rd_host_if.sv
// Bundle of request, AXI4 read-channel, sink and status signals for axi4_rd_host.
// The master modport is the host engine's view; slave is the surrounding environment.
interface axi4_rd_host_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) ();
  logic              ctrl_valid;
  logic              ctrl_ready;
  logic [31:0]       ctrl_address;
  logic [15:0]       ctrl_bytes;
  logic [2:0]        ctrl_size;
  logic [1:0]        ctrl_burst;

  logic [ID_W-1:0]   ar_id;
  logic [31:0]       ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [3:0]        ar_cache;
  logic              ar_lock;
  logic [2:0]        ar_prot;
  logic [3:0]        ar_qos;
  logic [3:0]        ar_region;
  logic              ar_valid;
  logic              ar_ready;

  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic              r_valid;
  logic              r_ready;

  logic [DATA_W-1:0] dout_data;
  logic              dout_last;
  logic              dout_valid;
  logic              dout_ready;

  logic              done_valid;
  logic [1:0]        done_resp;
  logic              busy;

  modport master (
    input  ctrl_valid, ctrl_address, ctrl_bytes, ctrl_size, ctrl_burst,
    output ctrl_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_lock,
           ar_prot, ar_qos, ar_region, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready,
    output dout_data, dout_last, dout_valid,
    input  dout_ready,
    output done_valid, done_resp, busy
  );

  modport slave (
    output ctrl_valid, ctrl_address, ctrl_bytes, ctrl_size, ctrl_burst,
    input  ctrl_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_lock,
           ar_prot, ar_qos, ar_region, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready,
    input  dout_data, dout_last, dout_valid,
    output dout_ready,
    input  done_valid, done_resp, busy
  );
endinterface

// File: rtl/axi4_rd_host.sv
// AXI4 read host: splits a byte-length request into legal AR bursts (one outstanding),
// forwards R data to a valid/ready sink with zero latency and reports one accumulated response.
module axi4_rd_host #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  axi4_rd_host_if.master  bus
);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [7:0] BEAT_BYTES  = 8'(DATA_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [16:0]     rem_q, rem_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic [8:0]      n_q, n_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [1:0]      resp_q, resp_d;

  logic [7:0]      req_sz_bytes;
  logic [16:0]     req_beats;
  logic            req_err;
  logic [12:0]     page_left;
  logic [8:0]      page_cap, rem_cap, n_burst;
  logic            over_len, final_burst, r_hs;
  logic [1:0]      beat_resp;

  function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Request decode: beat count and the illegal-request checks.
  always_comb begin
    req_sz_bytes = 8'd1 << bus.ctrl_size;
    req_beats    = ({1'b0, bus.ctrl_bytes} + {9'd0, req_sz_bytes} - 17'd1) >> bus.ctrl_size;
    req_err      = (req_sz_bytes > BEAT_BYTES)
                || ((bus.ctrl_address[7:0] & (req_sz_bytes - 8'd1)) != 8'd0)
                || (bus.ctrl_burst == 2'd3)
                || ((bus.ctrl_burst == BURST_WRAP)
                    && !(req_beats inside {17'd2, 17'd4, 17'd8, 17'd16}));
  end

  // Burst length: INCR bursts never cross a 4 KB page nor exceed 256 beats.
  always_comb begin
    page_left = (13'd4096 - {1'b0, addr_q[11:0]}) >> size_q;
    page_cap  = (page_left > 13'd256) ? 9'd256 : page_left[8:0];
    rem_cap   = (rem_q > 17'd256) ? 9'd256 : rem_q[8:0];
    case (burst_q)
      BURST_FIXED: n_burst = (rem_q > 17'd16) ? 9'd16 : rem_q[8:0];
      BURST_WRAP:  n_burst = rem_q[8:0];
      default:     n_burst = (rem_cap < page_cap) ? rem_cap : page_cap;
    endcase
  end

  assign over_len    = (cnt_q >= n_q);
  assign final_burst = (rem_q == {8'd0, n_q});

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    size_d    = size_q;
    burst_d   = burst_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    bid_d     = bid_q;
    resp_d    = resp_q;
    r_hs      = 1'b0;
    beat_resp = resp_q;

    bus.ctrl_ready = 1'b0;
    bus.ar_valid   = 1'b0;
    bus.r_ready    = 1'b0;
    bus.dout_valid = 1'b0;
    bus.dout_last  = 1'b0;
    bus.dout_data  = '0;
    bus.done_valid = 1'b0;
    bus.done_resp  = RESP_OKAY;

    case (state_q)
      S_IDLE: begin
        bus.ctrl_ready = 1'b1;
        if (bus.ctrl_valid) begin
          addr_d  = bus.ctrl_address;
          size_d  = bus.ctrl_size;
          burst_d = bus.ctrl_burst;
          rem_d   = req_beats;
          resp_d  = RESP_OKAY;
          if (bus.ctrl_bytes == 16'd0) begin
            state_d = S_DONE;
          end else if (req_err) begin
            resp_d  = RESP_SLVERR;
            state_d = S_DONE;
          end else begin
            state_d = S_AR;
          end
        end
      end

      S_AR: begin
        bus.ar_valid = 1'b1;
        if (bus.ar_ready) begin
          n_d     = n_burst;
          cnt_d   = '0;
          bid_d   = id_q;
          id_d    = id_q + 1'b1;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        // Beats past the advertised length are drained but never forwarded.
        bus.r_ready    = over_len ? 1'b1 : bus.dout_ready;
        bus.dout_valid = over_len ? 1'b0 : bus.r_valid;
        bus.dout_data  = bus.r_data;
        bus.dout_last  = bus.dout_valid && bus.r_last && final_burst;
        r_hs           = bus.r_valid && bus.r_ready;
        if (r_hs) begin
          cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 9'd1;
          beat_resp = rmax(resp_q, bus.r_resp);
          if ((bus.r_id != bid_q) || (bus.r_last && ((cnt_q + 9'd1) != n_q)))
            beat_resp = rmax(beat_resp, RESP_SLVERR);
          resp_d = beat_resp;
          if (bus.r_last) begin
            rem_d = rem_q - {8'd0, n_q};
            if (burst_q == BURST_INCR)
              addr_d = addr_q + (32'(n_q) << size_q);
            state_d = (rem_d != 17'd0) ? S_AR : S_DONE;
          end
        end
      end

      S_DONE: begin
        bus.done_valid = 1'b1;
        bus.done_resp  = resp_q;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      bid_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      bid_q   <= bid_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.ar_id     = id_q;
  assign bus.ar_addr   = addr_q;
  assign bus.ar_len    = (state_q == S_AR) ? (n_burst[7:0] - 8'd1) : '0;
  assign bus.ar_size   = size_q;
  assign bus.ar_burst  = burst_q;
  assign bus.ar_cache  = 4'b0000;
  assign bus.ar_lock   = 1'b0;
  assign bus.ar_prot   = 3'b000;
  assign bus.ar_qos    = 4'b0000;
  assign bus.ar_region = 4'b0000;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi4_rd_host.sv
// Bench for axi4_rd_host: background AXI read slave and sink, directed scenarios and
// randomized requests checked against a burst-splitting reference model.
module tb_axi4_rd_host;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_rd_host_if #(.DATA_W(DATA_W), .ID_W(ID_W)) bus ();
  axi4_rd_host #(.DATA_W(DATA_W), .ID_W(ID_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // environment configuration
  int       ar_stall_cfg = 0;
  bit       rnd = 0;
  int       sink_mode = 0;
  int       inj_a = -1, inj_b = -1;
  logic [1:0] inj_ra = 2'd0, inj_rb = 2'd0;
  bit       bad_id = 0, extra_beat = 0;

  // observations
  logic [31:0]       ar_addr_log[$];
  logic [7:0]        ar_len_log[$];
  logic [ID_W-1:0]   ar_id_log[$];
  logic [4:0]        ar_sb_log[$];
  logic [DATA_W-1:0] exp_data[$];
  logic [DATA_W-1:0] got_data[$];
  bit                got_last[$];
  int                done_cnt = 0;
  logic [1:0]        done_resp_log = 2'd0;
  int                stall_viol = 0, rready_viol = 0, gbeat = 0;

  // model
  logic [31:0] m_addr[$];
  int          m_len[$];
  int          m_id[$];
  int          exp_id = 0;

  // AXI read slave: one burst at a time, R beats held until accepted.
  initial begin : slave
    int b_len, b_beat, ar_wait;
    logic [ID_W-1:0] b_id, st_id;
    logic [31:0] st_addr;
    logic [7:0]  st_len;
    bit b_act, r_pend, st_valid;
    b_act = 0; r_pend = 0; st_valid = 0; ar_wait = 0; b_len = 0; b_beat = 0;
    b_id = '0; st_id = '0; st_addr = '0; st_len = '0;
    bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_id = '0; bus.r_data = '0;
    bus.r_resp = 2'd0; bus.r_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_act = 0; r_pend = 0; st_valid = 0; ar_wait = ar_stall_cfg;
        bus.r_valid = 1'b0; bus.ar_ready = 1'b0;
        continue;
      end
      if (ar_stall_cfg > 0) bus.ar_ready = (ar_wait == 0);
      else                  bus.ar_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_act && !r_pend) begin
        if (!rnd || $urandom_range(0, 3) != 0) begin
          bus.r_valid = 1'b1;
          bus.r_data  = DATA_W'($urandom);
          bus.r_id    = bad_id ? b_id + 1'b1 : b_id;
          bus.r_resp  = (gbeat == inj_a) ? inj_ra : (gbeat == inj_b) ? inj_rb : 2'd0;
          bus.r_last  = (b_beat == b_len + (extra_beat ? 1 : 0));
          r_pend = 1;
        end else bus.r_valid = 1'b0;
      end else if (!b_act) bus.r_valid = 1'b0;
      #4;
      if (st_valid && (!bus.ar_valid || bus.ar_addr !== st_addr ||
                       bus.ar_len !== st_len || bus.ar_id !== st_id)) stall_viol++;
      st_valid = bus.ar_valid && !bus.ar_ready;
      st_addr = bus.ar_addr; st_len = bus.ar_len; st_id = bus.ar_id;
      if (bus.ar_valid && bus.ar_ready) begin
        ar_addr_log.push_back(bus.ar_addr);
        ar_len_log.push_back(bus.ar_len);
        ar_id_log.push_back(bus.ar_id);
        ar_sb_log.push_back({bus.ar_size, bus.ar_burst});
        b_act = 1; b_len = int'(bus.ar_len); b_beat = 0; b_id = bus.ar_id;
        ar_wait = ar_stall_cfg;
      end else if (bus.ar_valid && ar_wait > 0) ar_wait--;
      if (bus.r_valid && bus.r_ready) begin
        if (b_beat <= b_len) exp_data.push_back(bus.r_data);
        r_pend = 0; gbeat++;
        if (bus.r_last) b_act = 0; else b_beat++;
      end
    end
  end

  // Sink and status monitor.
  initial begin : sink
    bus.dout_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (sink_mode)
        1:       bus.dout_ready = ~bus.dout_ready;
        2:       bus.dout_ready = 1'($urandom_range(0, 1));
        default: bus.dout_ready = 1'b1;
      endcase
      #4;
      if (bus.dout_valid && bus.dout_ready) begin
        got_data.push_back(bus.dout_data);
        got_last.push_back(bus.dout_last);
      end
      if (bus.done_valid) begin done_cnt++; done_resp_log = bus.done_resp; end
      if (bus.busy && bus.dout_valid && bus.r_ready !== bus.dout_ready) rready_viol++;
    end
  end

  function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic int data_errs();
    int e = 0;
    if (got_data.size() != exp_data.size()) return -1;
    foreach (got_data[i]) if (got_data[i] !== exp_data[i]) e++;
    return e;
  endfunction

  function automatic int last_count();
    int c = 0;
    foreach (got_last[i]) if (got_last[i]) c++;
    return c;
  endfunction

  // Reference: splits the request by the AXI rules (page, 256/16 beat caps).
  task automatic build_model(input logic [31:0] a, input int bytes, input int sz, input int bt,
                             output int total, output logic [1:0] base);
    int sb, beats, left, n, pg;
    logic [31:0] cur;
    sb = 1 << sz; beats = (bytes + sb - 1) >> sz;
    m_addr.delete(); m_len.delete(); m_id.delete();
    total = 0; base = 2'd0;
    if (bytes == 0) return;
    if (sb > DATA_W / 8 || (a % sb) != 0 || bt == 3 ||
        (bt == 2 && !(beats inside {2, 4, 8, 16}))) begin
      base = 2'd2; return;
    end
    total = beats; left = beats; cur = a;
    while (left > 0) begin
      if (bt == 1) begin
        pg = (4096 - int'(cur % 4096)) / sb;
        n = (left < 256) ? left : 256;
        if (pg < n) n = pg;
      end else if (bt == 0) n = (left < 16) ? left : 16;
      else n = left;
      m_addr.push_back(cur); m_len.push_back(n - 1); m_id.push_back(exp_id);
      exp_id = (exp_id + 1) % (1 << ID_W);
      left -= n;
      if (bt == 1) cur += 32'(n * sb);
    end
  endtask

  task automatic clear_logs();
    ar_addr_log.delete(); ar_len_log.delete(); ar_id_log.delete(); ar_sb_log.delete();
    exp_data.delete(); got_data.delete(); got_last.delete();
    done_cnt = 0; gbeat = 0; stall_viol = 0; rready_viol = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; exp_id = 0;
  endtask

  task automatic run_req(input logic [31:0] a, input int bytes, input int sz, input int bt,
                         output int total, output logic [1:0] base);
    bit acc = 0;
    build_model(a, bytes, sz, bt, total, base);
    clear_logs();
    @(negedge clk);
    bus.ctrl_valid = 1'b1; bus.ctrl_address = a; bus.ctrl_bytes = 16'(bytes);
    bus.ctrl_size = 3'(sz); bus.ctrl_burst = 2'(bt);
    for (int i = 0; i < 100 && !acc; i++) begin
      #4; if (bus.ctrl_ready) acc = 1;
      @(negedge clk);
    end
    bus.ctrl_valid = 1'b0;
    for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL done_pulses: got %0d expected 1 (addr %0h bytes %0d)", done_cnt, a, bytes);
    end
  endtask

  task automatic test_reset();
    bus.ctrl_valid = 1'b0; bus.ctrl_address = '0; bus.ctrl_bytes = '0;
    bus.ctrl_size = '0; bus.ctrl_burst = '0;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({bus.ctrl_ready, bus.busy, bus.ar_valid, bus.r_ready, bus.dout_valid, bus.done_valid,
         bus.ar_len, bus.ar_addr, bus.ar_id} !== {1'b1, 5'b0, 8'd0, 32'd0, 4'd0}) begin
      n_err++; $display("FAIL reset_outputs: ctrl_ready %b busy %b ar_valid %b expected 1 0 0",
                        bus.ctrl_ready, bus.busy, bus.ar_valid);
    end
    @(negedge clk); rst_n = 1'b1; exp_id = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.ar_cache, bus.ar_lock, bus.ar_prot, bus.ar_qos, bus.ar_region, bus.busy} !== '0) begin
      n_err++; $display("FAIL tied_zero: cache %h busy %b expected 0 0", bus.ar_cache, bus.busy);
    end
  endtask

  task automatic test_single_burst();
    int t; logic [1:0] b;
    run_req(32'h1000, 64, 2, 1, t, b);
    n_cmp++;
    if (ar_addr_log.size() != 1 || ar_addr_log[0] !== 32'h1000 || ar_len_log[0] !== 8'd15 ||
        ar_id_log[0] !== 4'd0) begin
      n_err++; $display("FAIL single_ar: count %0d expected 1 at 1000 len 15 id 0", ar_addr_log.size());
    end
    n_cmp++;
    if (data_errs() !== 0 || got_data.size() != 16) begin
      n_err++; $display("FAIL single_data: beats %0d errs %0d expected 16 0", got_data.size(), data_errs());
    end
    n_cmp++;
    if (last_count() != 1 || got_last.size() != 16 || !got_last[15]) begin
      n_err++; $display("FAIL single_last: count %0d expected 1 on beat 15", last_count());
    end
    n_cmp++;
    if (done_resp_log !== 2'd0) begin
      n_err++; $display("FAIL single_resp: got %0d expected 0", done_resp_log);
    end
  endtask

  task automatic test_page_split();
    int t; logic [1:0] b;
    do_reset();
    run_req(32'h0FF0, 32, 2, 1, t, b);
    n_cmp++;
    if (ar_addr_log.size() != 2 || ar_addr_log[0] !== 32'h0FF0 || ar_len_log[0] !== 8'd3 ||
        ar_addr_log[1] !== 32'h1000 || ar_len_log[1] !== 8'd3 ||
        ar_id_log[0] !== 4'd0 || ar_id_log[1] !== 4'd1) begin
      n_err++; $display("FAIL page_split_ar: count %0d expected 2 bursts ff0/1000 len 3 ids 0 1",
                        ar_addr_log.size());
    end
    n_cmp++;
    if (data_errs() !== 0 || got_data.size() != 8 || last_count() != 1 || !got_last[7]) begin
      n_err++; $display("FAIL page_split_data: beats %0d lasts %0d expected 8 1",
                        got_data.size(), last_count());
    end
  endtask

  task automatic test_ar_stall();
    int t; logic [1:0] b;
    ar_stall_cfg = 5;
    run_req(32'h0, 2048, 2, 1, t, b);
    ar_stall_cfg = 0;
    n_cmp++;
    if (ar_addr_log.size() != 2 || ar_addr_log[0] !== 32'h0 || ar_len_log[0] !== 8'd255 ||
        ar_addr_log[1] !== 32'h400 || ar_len_log[1] !== 8'd255) begin
      n_err++; $display("FAIL stall_ar: count %0d expected 2 bursts 0/400 len 255", ar_addr_log.size());
    end
    n_cmp++;
    if (stall_viol !== 0) begin
      n_err++; $display("FAIL stall_stable: changes %0d expected 0", stall_viol);
    end
    n_cmp++;
    if (data_errs() !== 0 || got_data.size() != 512 || done_resp_log !== 2'd0) begin
      n_err++; $display("FAIL stall_data: beats %0d resp %0d expected 512 0", got_data.size(), done_resp_log);
    end
  endtask

  task automatic test_errors();
    int t; logic [1:0] b;
    logic [31:0] ea[6] = '{32'h0, 32'h2, 32'h0, 32'h0, 32'h0, 32'h40};
    int eby[6] = '{0, 16, 16, 16, 12, 16};
    int esz[6] = '{2, 2, 3, 2, 2, 2};
    int ebt[6] = '{1, 1, 1, 3, 2, 2};
    logic [1:0] er[6] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    int ear[6] = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      run_req(ea[i], eby[i], esz[i], ebt[i], t, b);
      n_cmp++;
      if (done_resp_log !== er[i] || ar_addr_log.size() != ear[i]) begin
        n_err++; $display("FAIL error_case%0d: resp %0d ars %0d expected %0d %0d",
                          i, done_resp_log, ar_addr_log.size(), er[i], ear[i]);
      end
    end
    n_cmp++;
    if (ar_sb_log.size() != 1 || ar_sb_log[0] !== {3'd2, 2'd2} || ar_len_log[0] !== 8'd3) begin
      n_err++; $display("FAIL wrap_ar: ars %0d expected one WRAP len 3", ar_sb_log.size());
    end
    bad_id = 1;
    run_req(32'h100, 16, 2, 1, t, b);
    bad_id = 0;
    n_cmp++;
    if (done_resp_log !== 2'd2 || got_data.size() != 4) begin
      n_err++; $display("FAIL bad_id: resp %0d beats %0d expected 2 4", done_resp_log, got_data.size());
    end
    extra_beat = 1;
    run_req(32'h200, 16, 2, 1, t, b);
    extra_beat = 0;
    n_cmp++;
    if (done_resp_log !== 2'd2 || data_errs() !== 0 || got_data.size() != 4 || last_count() != 0) begin
      n_err++; $display("FAIL extra_beat: resp %0d beats %0d lasts %0d expected 2 4 0",
                        done_resp_log, got_data.size(), last_count());
    end
  endtask

  task automatic test_resp_accum();
    int t; logic [1:0] b;
    sink_mode = 1; inj_a = 3; inj_ra = 2'd2; inj_b = 7; inj_rb = 2'd3;
    run_req(32'h3000, 64, 2, 1, t, b);
    sink_mode = 0; inj_a = -1; inj_b = -1;
    n_cmp++;
    if (done_resp_log !== 2'd3) begin
      n_err++; $display("FAIL resp_accum: got %0d expected 3", done_resp_log);
    end
    n_cmp++;
    if (rready_viol !== 0 || data_errs() !== 0 || got_data.size() != 16) begin
      n_err++; $display("FAIL ready_track: viol %0d beats %0d expected 0 16", rready_viol, got_data.size());
    end
  endtask

  task automatic test_mid_reset();
    int t; logic [1:0] b;
    build_model(32'h5000, 64, 2, 1, t, b);
    clear_logs();
    @(negedge clk);
    bus.ctrl_valid = 1'b1; bus.ctrl_address = 32'h5000; bus.ctrl_bytes = 16'd64;
    bus.ctrl_size = 3'd2; bus.ctrl_burst = 2'd1;
    @(negedge clk); bus.ctrl_valid = 1'b0;
    for (int i = 0; i < 200 && got_data.size() < 3; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ar_valid, bus.r_ready, bus.dout_valid, bus.dout_last, bus.done_valid, bus.busy} !== 6'b0
        || got_data.size() < 3) begin
      n_err++; $display("FAIL mid_reset: busy %b dout_valid %b beats %0d expected 0 0 >=3",
                        bus.busy, bus.dout_valid, got_data.size());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; exp_id = 0;
    run_req(32'h40, 16, 2, 1, t, b);
    n_cmp++;
    if (ar_id_log.size() != 1 || ar_id_log[0] !== 4'd0 || done_resp_log !== 2'd0 ||
        got_data.size() != 4) begin
      n_err++; $display("FAIL post_reset: ars %0d resp %0d beats %0d expected 1 id0 0 4",
                        ar_id_log.size(), done_resp_log, got_data.size());
    end
  endtask

  task automatic test_random();
    int t, sz, bt, bytes, sb, bad;
    logic [1:0] base, er;
    logic [31:0] a;
    rnd = 1; sink_mode = 2;
    for (int k = 0; k < 25; k++) begin
      sz = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 2)) : 3;
      sb = 1 << sz;
      bt = int'($urandom_range(0, 9));
      bt = (bt < 2) ? 0 : (bt < 7) ? 1 : (bt < 9) ? 2 : 3;
      a = 32'($urandom_range(0, 12287));
      if ($urandom_range(0, 7) != 0) a = a & ~32'(sb - 1);
      if (bt == 2 && $urandom_range(0, 3) != 0)
        bytes = sb * (2 << $urandom_range(0, 3)) - int'($urandom_range(0, sb - 1));
      else
        bytes = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 400));
      inj_a = int'($urandom_range(0, 40)); inj_ra = 2'($urandom_range(0, 3));
      inj_b = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 40)) : -1;
      inj_rb = 2'($urandom_range(0, 3));
      run_req(a, bytes, sz, bt, t, base);
      er = base;
      if (inj_a >= 0 && inj_a < t) er = rmax(er, inj_ra);
      if (inj_b >= 0 && inj_b < t) er = rmax(er, inj_rb);
      bad = (ar_addr_log.size() != m_addr.size()) ? 1 : 0;
      if (bad == 0)
        foreach (m_addr[i])
          if (ar_addr_log[i] !== m_addr[i] || ar_len_log[i] !== 8'(m_len[i]) ||
              ar_id_log[i] !== ID_W'(m_id[i]) || ar_sb_log[i] !== {3'(sz), 2'(bt)}) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_err++; $display("FAIL rand%0d_ar: ars %0d bad %0d expected %0d bursts (a %0h b %0d sz %0d bt %0d)",
                          k, ar_addr_log.size(), bad, m_addr.size(), a, bytes, sz, bt);
      end
      n_cmp++;
      if (got_data.size() != t || data_errs() !== 0) begin
        n_err++; $display("FAIL rand%0d_data: beats %0d expected %0d", k, got_data.size(), t);
      end
      n_cmp++;
      if (last_count() != ((t > 0) ? 1 : 0) || (t > 0 && got_last.size() == t && !got_last[t-1])) begin
        n_err++; $display("FAIL rand%0d_last: count %0d expected %0d", k, last_count(), (t > 0) ? 1 : 0);
      end
      n_cmp++;
      if (done_resp_log !== er || stall_viol !== 0) begin
        n_err++; $display("FAIL rand%0d_resp: resp %0d stall %0d expected %0d 0", k, done_resp_log, stall_viol, er);
      end
    end
    rnd = 0; sink_mode = 0; inj_a = -1; inj_b = -1;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_page_split();
    test_ar_stall();
    test_errors();
    test_resp_accum();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
